// File: rtl/assert_monitor_pkg.sv
// Shared types and helpers for the assertion monitor.
//   state_t    : monitor FSM states
//   MAX_CH     : upper bound on checker channel count
//   lowest_set : index of the lowest set bit of a channel vector (0 if none)
package assert_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  localparam int MAX_CH = 32;

  function automatic logic [4:0] lowest_set(input logic [MAX_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    // Walk down so the last hit, the lowest index, wins.
    for (int i = MAX_CH - 1; i >= 0; i--)
      if (v[i]) idx = 5'(i);
    return idx;
  endfunction

endpackage

// File: rtl/assert_monitor_core.sv
// Assertion monitor core: FSM, sticky fail flags, saturating per-channel
// counters, one-entry event slot with drop counter, free-running timestamp.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   arm, clear          control pulses (clear wins over everything)
//   en, cond            per-channel enable / property value
//   evt_ready           consumer handshake
//   fail, tripped, first_ch, fail_cnt       status outputs (registered)
//   evt_valid, evt_ch, evt_ts, evt_drop     event port (registered)
module assert_monitor_core
  import assert_monitor_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       clear,
  input  logic [N_CH-1:0]            en,
  input  logic [N_CH-1:0]            cond,
  input  logic                       evt_ready,
  output logic [N_CH-1:0]            fail,
  output logic                       tripped,
  output logic [CH_W-1:0]            first_ch,
  output logic [N_CH-1:0][CNT_W-1:0] fail_cnt,
  output logic                       evt_valid,
  output logic [CH_W-1:0]            evt_ch,
  output logic [TS_W-1:0]            evt_ts,
  output logic [CNT_W-1:0]           evt_drop
);

  state_t            state;
  logic [TS_W-1:0]   ts;
  logic [N_CH-1:0]   vio;
  logic [MAX_CH-1:0] vio_ext;
  logic              any_v;
  logic [CH_W-1:0]   lo;

  // Checking is live in ARMED and TRIPPED; IDLE masks every channel.
  assign vio     = (state != IDLE) ? (en & ~cond) : '0;
  assign vio_ext = MAX_CH'(vio);
  assign any_v   = |vio;
  assign lo      = CH_W'(lowest_set(vio_ext));

  // Timestamp runs from reset regardless of state; clear does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tripped  <= 1'b0;
      first_ch <= '0;
    end else if (clear) begin
      state    <= IDLE;
      tripped  <= 1'b0;
      first_ch <= '0;
    end else begin
      case (state)
        IDLE:    if (arm) state <= ARMED;
        ARMED:   if (any_v) begin
                   state    <= TRIPPED;
                   tripped  <= 1'b1;
                   first_ch <= lo;
                 end
        default: ;  // TRIPPED holds until clear
      endcase
    end
  end

  // Per-channel sticky flag and saturating counter.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fail[c]     <= 1'b0;
        fail_cnt[c] <= '0;
      end else if (clear) begin
        fail[c]     <= 1'b0;
        fail_cnt[c] <= '0;
      end else if (vio[c]) begin
        fail[c] <= 1'b1;
        if (fail_cnt[c] != '1) fail_cnt[c] <= fail_cnt[c] + CNT_W'(1);
      end
    end
  end

  // One-entry event slot. A pop in the same cycle frees the slot for the
  // new event; otherwise the held event stays put and the loss is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_ts    <= '0;
      evt_drop  <= '0;
    end else if (clear) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_ts    <= '0;
      evt_drop  <= '0;
    end else if (any_v) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_ch    <= lo;
        evt_ts    <= ts;
      end else if (evt_drop != '1) begin
        evt_drop <= evt_drop + CNT_W'(1);
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/assert_monitor_guarded.sv
// Compile-guarded assertion monitor wrapper. O = I always (zero latency).
// With ASSERT_ON defined the core checks EN & ~COND per channel; without it
// every monitor output is tied to 0 and the control inputs are ignored.
// Ports: CLK, ASYNCRESETN, I/O pass-through, ARM, CLEAR, EN, COND,
//   FAIL, TRIPPED, FIRST_CH, FAIL_CNT (channel c at [c*CNT_W +: CNT_W]),
//   EVT_VALID/EVT_READY/EVT_CH/EVT_TS event port, EVT_DROP lost-event count.
module assert_monitor_guarded #(
  parameter int W     = 8,
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [W-1:0]          I,
  output logic [W-1:0]          O,
  input  logic                  ARM,
  input  logic                  CLEAR,
  input  logic [N_CH-1:0]       EN,
  input  logic [N_CH-1:0]       COND,
  output logic [N_CH-1:0]       FAIL,
  output logic                  TRIPPED,
  output logic [CH_W-1:0]       FIRST_CH,
  output logic [N_CH*CNT_W-1:0] FAIL_CNT,
  output logic                  EVT_VALID,
  input  logic                  EVT_READY,
  output logic [CH_W-1:0]       EVT_CH,
  output logic [TS_W-1:0]       EVT_TS,
  output logic [CNT_W-1:0]      EVT_DROP
);

  assign O = I;

`ifdef ASSERT_ON
  logic [N_CH-1:0][CNT_W-1:0] fail_cnt;

  assert_monitor_core #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .TS_W  (TS_W)
  ) u_core (
    .clk       (CLK),
    .rst_n     (ASYNCRESETN),
    .arm       (ARM),
    .clear     (CLEAR),
    .en        (EN),
    .cond      (COND),
    .evt_ready (EVT_READY),
    .fail      (FAIL),
    .tripped   (TRIPPED),
    .first_ch  (FIRST_CH),
    .fail_cnt  (fail_cnt),
    .evt_valid (EVT_VALID),
    .evt_ch    (EVT_CH),
    .evt_ts    (EVT_TS),
    .evt_drop  (EVT_DROP)
  );

  assign FAIL_CNT = fail_cnt;
`else
  logic unused_inputs;
  assign unused_inputs = ^{CLK, ASYNCRESETN, ARM, CLEAR, EN, COND, EVT_READY};

  assign FAIL      = '0;
  assign TRIPPED   = 1'b0;
  assign FIRST_CH  = '0;
  assign FAIL_CNT  = '0;
  assign EVT_VALID = 1'b0;
  assign EVT_CH    = '0;
  assign EVT_TS    = '0;
  assign EVT_DROP  = '0;
`endif

endmodule

// File: tb/tb_assert_monitor_guarded.sv
// Self-checking bench: directed scenarios then random stimulus, compared to
// a behavioural model. A second instance with CNT_W=2 exercises saturation.
module tb_assert_monitor_guarded;

`ifdef ASSERT_ON
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  d_in = '0;
  logic        arm = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [3:0]  en = '0, cond = '0;

  logic [7:0]  o_out, o_out2;
  logic [3:0]  fail, fail2;
  logic        tripped, tripped2, evt_valid, evt_valid2;
  logic [1:0]  first_ch, first_ch2, evt_ch, evt_ch2;
  logic [31:0] fail_cnt;
  logic [7:0]  fail_cnt2;
  logic [15:0] evt_ts, evt_ts2;
  logic [7:0]  evt_drop;
  logic [1:0]  evt_drop2;

  always #5 clk = ~clk;

  assert_monitor_guarded #(.W(8), .N_CH(4), .CNT_W(8), .TS_W(16)) dut (
    .CLK(clk), .ASYNCRESETN(rst_n), .I(d_in), .O(o_out), .ARM(arm), .CLEAR(clr),
    .EN(en), .COND(cond), .FAIL(fail), .TRIPPED(tripped), .FIRST_CH(first_ch),
    .FAIL_CNT(fail_cnt), .EVT_VALID(evt_valid), .EVT_READY(rdy), .EVT_CH(evt_ch),
    .EVT_TS(evt_ts), .EVT_DROP(evt_drop));

  assert_monitor_guarded #(.W(8), .N_CH(4), .CNT_W(2), .TS_W(16)) dut2 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I(d_in), .O(o_out2), .ARM(arm), .CLEAR(clr),
    .EN(en), .COND(cond), .FAIL(fail2), .TRIPPED(tripped2), .FIRST_CH(first_ch2),
    .FAIL_CNT(fail_cnt2), .EVT_VALID(evt_valid2), .EVT_READY(rdy), .EVT_CH(evt_ch2),
    .EVT_TS(evt_ts2), .EVT_DROP(evt_drop2));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int ch; int ts; } evt_t;
  evt_t q[$];
  bit   m_active, m_tripped;
  bit   m_fail [4];
  int   m_cnt8 [4];
  int   m_cnt2 [4];
  int   m_first, m_drop8, m_drop2, m_ts;

  function automatic int sat(input int v, input int lim);
    return (v + 1 > lim) ? lim : v + 1;
  endfunction

  task automatic model_clear();
    m_active = 0; m_tripped = 0; m_first = 0; m_drop8 = 0; m_drop2 = 0;
    q.delete();
    for (int c = 0; c < 4; c++) begin
      m_fail[c] = 0; m_cnt8[c] = 0; m_cnt2[c] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    m_ts = 0;
  endtask

  // Applies the rules at one rising edge, using the inputs in force.
  task automatic model_step();
    int lo;
    if (MON) begin
      if (clr) begin
        model_clear();
      end else if (m_active) begin
        lo = -1;
        for (int c = 0; c < 4; c++)
          if (en[c] && !cond[c]) begin
            m_fail[c] = 1;
            m_cnt8[c] = sat(m_cnt8[c], 255);
            m_cnt2[c] = sat(m_cnt2[c], 3);
            if (lo < 0) lo = c;
          end
        if (lo >= 0) begin
          if (!m_tripped) begin m_tripped = 1; m_first = lo; end
          if (q.size() == 0 || rdy) begin
            q.delete();
            q.push_back('{lo, m_ts});
          end else begin
            m_drop8 = sat(m_drop8, 255);
            m_drop2 = sat(m_drop2, 3);
          end
        end else if (q.size() != 0 && rdy) begin
          q.delete();
        end
      end else if (arm) begin
        m_active = 1;
      end
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_all();
    logic [3:0]  ef;
    logic [31:0] ec;
    logic [7:0]  ec2;
    for (int c = 0; c < 4; c++) begin
      ef[c]          = m_fail[c];
      ec[c*8 +: 8]   = 8'(m_cnt8[c]);
      ec2[c*2 +: 2]  = 2'(m_cnt2[c]);
    end
    chk("O",         64'(o_out),     64'(d_in));
    chk("FAIL",      64'(fail),      64'(ef));
    chk("TRIPPED",   64'(tripped),   64'(m_tripped));
    chk("FIRST_CH",  64'(first_ch),  64'(m_first));
    chk("FAIL_CNT",  64'(fail_cnt),  64'(ec));
    chk("EVT_VALID", 64'(evt_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("EVT_CH", 64'(evt_ch), 64'(q[0].ch));
      chk("EVT_TS", 64'(evt_ts), 64'(q[0].ts));
    end
    chk("EVT_DROP",  64'(evt_drop),  64'(m_drop8));
    chk("CNT_SAT2",  64'(fail_cnt2), 64'(ec2));
    chk("DROP_SAT2", 64'(evt_drop2), 64'(m_drop2));
  endtask

  // Drive at edge+1, let the edge happen, advance the model, check at edge+1.
  task automatic cycle(input logic a, input logic c, input logic [3:0] e,
                       input logic [3:0] k, input logic r, input logic [7:0] d);
    arm = a; clr = c; en = e; cond = k; rdy = r; d_in = d;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  // Reset pulled between edges: outputs must clear before the next edge.
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check_all();

    // idle: violations ignored, data passes through
    repeat (5) cycle(0, 0, 4'hF, 4'h0, 0, 8'hA5);

    // arm, then two channels violate together
    cycle(1, 0, 4'h0, 4'hF, 0, 8'h11);
    cycle(0, 0, 4'b0110, 4'b0000, 1, 8'h22);
    chk("t2_first_ch", 64'(first_ch), MON ? 64'd1 : 64'd0);
    chk("t2_cnt2",     64'(fail_cnt[23:16]), MON ? 64'd1 : 64'd0);

    // drain, then ch3 violates 4 cycles while consumer stalls
    cycle(0, 0, 4'h0, 4'hF, 1, 8'h33);
    repeat (4) cycle(0, 0, 4'b1000, 4'b0000, 0, 8'h44);
    chk("t3_drop", 64'(evt_drop), MON ? 64'd3 : 64'd0);
    chk("t3_cnt3", 64'(fail_cnt[31:24]), MON ? 64'd4 : 64'd0);

    // ch0 violates 6 cycles: 2-bit counter pins at 3
    repeat (6) cycle(0, 0, 4'b0001, 4'b0000, 1, 8'h55);
    chk("t4_sat", 64'(fail_cnt2[1:0]), MON ? 64'd3 : 64'd0);

    // clear + arm + violation together: clear wins, back to idle
    cycle(1, 1, 4'hF, 4'h0, 0, 8'h66);
    chk("t5_trip", 64'(tripped), 64'd0);
    cycle(0, 0, 4'hF, 4'h0, 1, 8'h77);

    // pending event killed by asynchronous reset
    cycle(1, 0, 4'h0, 4'hF, 0, 8'h88);
    cycle(0, 0, 4'b0010, 4'b0000, 0, 8'h99);
    mid_reset();

    // random traffic with stall phases and occasional reset
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [3:0] k;
      r = ((i / 24) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      k = 4'($urandom) | 4'($urandom);
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
            4'($urandom), k, r, 8'($urandom));
      if (i % 200 == 199) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
